// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests and buffers words for IF/ID.
// Optional macro FETCH_RSP_BYPASS_EN forwards a response straight to IF/ID when the buffer is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic [31:0] new_pc,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    input  logic        if_id_ready,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW:0]   outstanding_q, outstanding_d;
    logic [AW:0]   drop_cnt_q, drop_cnt_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
    logic [31:0]   buf_pc_q [FIFO_DEPTH];
    logic [31:0]   buf_pc_d [FIFO_DEPTH];
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic [31:0]   buf_instr_d [FIFO_DEPTH];
    logic [31:0]   shadow_pc_q [FIFO_DEPTH];
    logic [31:0]   shadow_pc_d [FIFO_DEPTH];

    logic          redirect_s, clear_s, head_valid_s, bypass_s, pop_s, push_s, issue_s;
    logic [AW+1:0] credit_s;
    logic          unused_s;

    assign unused_s     = ^new_pc[1:0];
    assign redirect_s   = pc_src && (state_q != BOOT);
    assign clear_s      = redirect_s || flush;
    assign head_valid_s = (count_q != ZERO_C);

`ifdef FETCH_RSP_BYPASS_EN
    assign bypass_s = (count_q == ZERO_C) && (state_q == RUN) && imem_rsp_valid && !pc_src && !flush;
`else
    assign bypass_s = 1'b0;
`endif

    // A head dequeued this cycle already returns its credit, keeping issue at one per cycle.
    assign pop_s    = head_valid_s && if_id_ready && !clear_s;
    assign credit_s = {1'b0, outstanding_q} + {1'b0, count_q} - {{(AW+1){1'b0}}, pop_s};
    assign push_s   = imem_rsp_valid && (state_q == RUN) && !redirect_s && !(bypass_s && if_id_ready);
    assign issue_s  = imem_req_valid && imem_req_ready;

    // Request channel and IF/ID presentation.
    always_comb begin
        imem_req_valid    = (state_q == RUN) && !pc_src && (credit_s < DEPTH_C);
        imem_req_addr     = fetch_pc_q;
        if_id_valid       = head_valid_s || bypass_s;
        if (head_valid_s) begin
            if_id_pc          = buf_pc_q[rd_ptr_q];
            if_id_instruction = buf_instr_q[rd_ptr_q];
        end else if (bypass_s) begin
            if_id_pc          = shadow_pc_q[sh_rd_q];
            if_id_instruction = imem_rsp_data;
        end else begin
            if_id_pc          = 32'h0000_0000;
            if_id_instruction = NOP;
        end
    end

    // Fetch PC, in-flight accounting and the PC shadow queue.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        sh_wr_d     = sh_wr_q;
        sh_rd_d     = sh_rd_q;
        shadow_pc_d = shadow_pc_q;
        if (redirect_s) begin
            fetch_pc_d = {new_pc[31:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (issue_s) begin
            shadow_pc_d[sh_wr_q] = fetch_pc_q;
            sh_wr_d              = sh_wr_q + 1'b1;
        end else begin
            sh_wr_d = sh_wr_q;
        end
        if (imem_rsp_valid) begin
            sh_rd_d = sh_rd_q + 1'b1;
        end else begin
            sh_rd_d = sh_rd_q;
        end
        if (issue_s && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + ONE_C;
        end else if (!issue_s && imem_rsp_valid) begin
            outstanding_d = outstanding_q - ONE_C;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Fetch buffer: cleared by any flush, then a same-cycle push may still land.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (clear_s) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = ZERO_C;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end
        if (push_s) begin
            buf_pc_d[wr_ptr_d]    = shadow_pc_q[sh_rd_q];
            buf_instr_d[wr_ptr_d] = imem_rsp_data;
            wr_ptr_d              = wr_ptr_d + 1'b1;
            count_d               = count_d + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_d;
        end
    end

    // FSM: every word owed at a redirect is stale, so drop_cnt tracks the post-cycle owed count.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, DRAIN: begin
                if (pc_src) begin
                    drop_cnt_d = outstanding_d;
                    state_d    = (outstanding_d != ZERO_C) ? DRAIN : RUN;
                end else if ((state_q == DRAIN) && imem_rsp_valid) begin
                    drop_cnt_d = drop_cnt_q - ONE_C;
                    state_d    = (drop_cnt_q == ONE_C) ? RUN : DRAIN;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= ZERO_C;
            drop_cnt_q    <= ZERO_C;
            count_q       <= ZERO_C;
            rd_ptr_q      <= {AW{1'b0}};
            wr_ptr_q      <= {AW{1'b0}};
            sh_rd_q       <= {AW{1'b0}};
            sh_wr_q       <= {AW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]    <= 32'h0000_0000;
                buf_instr_q[i] <= 32'h0000_0000;
                shadow_pc_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            sh_rd_q       <= sh_rd_d;
            sh_wr_q       <= sh_wr_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
            shadow_pc_q   <= shadow_pc_d;
        end
    end
endmodule
